// File: rtl/pulse_pacer_pkg.sv
// Shared types and helpers for the pulse pacer: state encoding and a
// width helper used to size the gap timer.
package pulse_pacer_pkg;

  typedef enum logic {
    READY = 1'b0,
    WAIT  = 1'b1
  } pace_state_e;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'(1) << i) < 33'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pulse_pacer_if.sv
// Request/pulse bundle between the pacer and its source-side user.
interface pulse_pacer_if #(
  parameter int unsigned CW = 8
);
  logic          din;
  logic          ovf_clr;
  logic          dout;
  logic [CW-1:0] pending;
  logic          busy;
  logic          overflow;

  modport master (output din, ovf_clr, input dout, pending, busy, overflow);
  modport slave  (input din, ovf_clr, output dout, pending, busy, overflow);
endinterface

// File: rtl/pulse_pacer_sat_updown_cnt.sv
// Saturating up/down counter; flags an increment that was dropped because
// the count was already at its maximum.
module pulse_pacer_sat_updown_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full_drop_c
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Simultaneous inc and dec cancel; decrement never goes below zero.
  always_comb begin
    cnt_d       = cnt_q;
    full_drop_c = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) full_drop_c = 1'b1;
      else                  cnt_d       = cnt_q + CW'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pulse_pacer.sv
// Meters request pulses into one-cycle output pulses spaced at least GAP+1
// cycles apart, buffering the backlog in a saturating counter.
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int unsigned CW  = 8,
  parameter int unsigned GAP = 3
) (
  input  logic         clk,
  input  logic         reset,
  pulse_pacer_if.slave io
);

  localparam int unsigned   TW     = clog2_min1(GAP + 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP);

  pace_state_e   state_c;
  logic          issue_c;
  logic          drop_c;
  logic [CW-1:0] pending_c;
  logic [TW-1:0] timer_q, timer_d;
  logic          dout_q, dout_d;
  logic          overflow_q, overflow_d;

  pulse_pacer_sat_updown_cnt #(.CW(CW)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .inc         (io.din),
    .dec         (issue_c),
    .cnt         (pending_c),
    .full_drop_c (drop_c)
  );

  // With GAP=0 the timer only ever loads zero, so the pacer stays READY.
  assign state_c = (timer_q == '0) ? READY : WAIT;

  always_comb begin
    issue_c    = 1'b0;
    timer_d    = timer_q;
    dout_d     = 1'b0;
    overflow_d = overflow_q;
    unique case (state_c)
      READY: begin
        issue_c = (pending_c != '0) || io.din;
        if (issue_c) timer_d = GAP_LD;
      end
      WAIT: timer_d = timer_q - TW'(1);
    endcase
    dout_d = issue_c;
    // A fresh drop outranks a simultaneous clear.
    if (drop_c)          overflow_d = 1'b1;
    else if (io.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      dout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
    end
  end

  assign io.dout     = dout_q;
  assign io.pending  = pending_c;
  assign io.overflow = overflow_q;
  assign io.busy     = (pending_c != '0) || (timer_q != '0);

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer: GAP=3 and GAP=0 builds with CW=4.
module tb_pulse_pacer;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_dout;

  always #5 clk = ~clk;

  pulse_pacer_if #(.CW(CW)) bus3 ();
  pulse_pacer_if #(.CW(CW)) bus0 ();

  pulse_pacer #(.CW(CW), .GAP(3)) u_dut3 (.clk(clk), .reset(reset), .io(bus3));
  pulse_pacer #(.CW(CW), .GAP(0)) u_dut0 (.clk(clk), .reset(reset), .io(bus0));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned burst_pending(input int r);
    if (r < 12)  return 0;
    if (r == 12) return 1;
    if (r == 13) return 2;
    if (r <= 18) return 3;
    if (r <= 22) return 2;
    if (r <= 26) return 1;
    return 0;
  endfunction

  initial begin
    reset = 1'b1;
    bus3.din = 1'b0; bus3.ovf_clr = 1'b0;
    bus0.din = 1'b0; bus0.ovf_clr = 1'b0;
    repeat (3) tick();

    check_eq("rst dout3",     32'(bus3.dout),     32'(0));
    check_eq("rst pending3",  32'(bus3.pending),  32'(0));
    check_eq("rst busy3",     32'(bus3.busy),     32'(0));
    check_eq("rst overflow3", 32'(bus3.overflow), 32'(0));
    check_eq("rst dout0",     32'(bus0.dout),     32'(0));
    check_eq("rst pending0",  32'(bus0.pending),  32'(0));
    reset = 1'b0;

    // Single request
    for (int r = 0; r <= 20; r++) begin
      tick();
      check_eq($sformatf("single dout r%0d", r),    32'(bus3.dout),    32'(r == 11));
      check_eq($sformatf("single pending r%0d", r), 32'(bus3.pending), 32'(0));
      check_eq($sformatf("single busy r%0d", r),    32'(bus3.busy),    32'(r >= 11 && r <= 13));
      bus3.din = (r == 10);
    end

    // Burst of five back-to-back requests
    for (int r = 0; r <= 35; r++) begin
      tick();
      check_eq($sformatf("burst dout r%0d", r), 32'(bus3.dout),
               32'(r == 11 || r == 15 || r == 19 || r == 23 || r == 27));
      check_eq($sformatf("burst pending r%0d", r), 32'(bus3.pending), 32'(burst_pending(r)));
      check_eq($sformatf("burst busy r%0d", r),    32'(bus3.busy),    32'(r >= 11 && r <= 29));
      check_eq($sformatf("burst ovf r%0d", r),     32'(bus3.overflow), 32'(0));
      bus3.din = (r >= 10 && r <= 14);
    end

    // Saturation, drops and overflow clear
    n_dout = 0;
    for (int r = 0; r <= 100; r++) begin
      tick();
      if (bus3.dout) n_dout++;
      check_eq($sformatf("ovf flag r%0d", r), 32'(bus3.overflow), 32'(r >= 32 && r <= 40));
      if (r == 29) check_eq("ovf pending r29", 32'(bus3.pending), 32'(14));
      if (r == 30) check_eq("ovf pending r30", 32'(bus3.pending), 32'(15));
      if (r == 33) check_eq("ovf pending r33", 32'(bus3.pending), 32'(15));
      if (r == 34) check_eq("ovf pending r34", 32'(bus3.pending), 32'(15));
      if (r == 35) check_eq("ovf pending r35", 32'(bus3.pending), 32'(14));
      bus3.din     = (r >= 10 && r <= 33);
      bus3.ovf_clr = (r == 40);
    end
    check_eq("ovf dout count", 32'(n_dout),        32'(21));
    check_eq("ovf pending end", 32'(bus3.pending), 32'(0));
    check_eq("ovf busy end",   32'(bus3.busy),     32'(0));

    // Clear coincident with a drop: the drop wins
    for (int r = 0; r <= 26; r++) begin
      tick();
      if (r == 20) check_eq("coin pending r20", 32'(bus3.pending),  32'(15));
      if (r == 20) check_eq("coin ovf r20",     32'(bus3.overflow), 32'(0));
      if (r == 22) check_eq("coin ovf r22",     32'(bus3.overflow), 32'(1));
      if (r == 24) check_eq("coin ovf r24",     32'(bus3.overflow), 32'(1));
      if (r == 25) check_eq("coin ovf r25",     32'(bus3.overflow), 32'(0));
      bus3.din     = (r <= 23);
      bus3.ovf_clr = (r == 23 || r == 24);
    end
    bus3.din = 1'b0; bus3.ovf_clr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset mid-burst while WAIT with a backlog of five
    for (int r = 0; r <= 27; r++) begin
      tick();
      if (r == 7) begin
        check_eq("mid pending r7", 32'(bus3.pending), 32'(5));
        check_eq("mid busy r7",    32'(bus3.busy),    32'(1));
        check_eq("mid ovf r7",     32'(bus3.overflow), 32'(0));
      end
      if (r >= 8) begin
        check_eq($sformatf("post-rst dout r%0d", r),    32'(bus3.dout),    32'(0));
        check_eq($sformatf("post-rst pending r%0d", r), 32'(bus3.pending), 32'(0));
        check_eq($sformatf("post-rst busy r%0d", r),    32'(bus3.busy),    32'(0));
      end
      bus3.din = (r <= 6);
      reset    = (r == 7);
    end
    bus3.din = 1'b0;
    reset    = 1'b0;

    // GAP=0 build: back-to-back pulses pass straight through
    for (int r = 0; r <= 16; r++) begin
      tick();
      check_eq($sformatf("gap0 dout r%0d", r),    32'(bus0.dout),    32'(r >= 11 && r <= 13));
      check_eq($sformatf("gap0 pending r%0d", r), 32'(bus0.pending), 32'(0));
      check_eq($sformatf("gap0 busy r%0d", r),    32'(bus0.busy),    32'(0));
      bus0.din = (r >= 10 && r <= 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
